// File: rtl/custom_cnt_unit.sv
// Bit-counting coprocessor unit (CNTB / CLZ / CTZ), CHUNK bits per cycle.
// Latency: N = XLEN/CHUNK busy cycles after issue; result held until result_ready_i.
module custom_cnt_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CHUNK    = 8,
    parameter int unsigned ID_WIDTH = 4,
    parameter logic [6:0]  OPCODE   = 7'b0001011
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    output logic                issue_accept_o,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [6:0]          opcode_i,
    input  logic [2:0]          funct3_i,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic                kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic                busy_o
);

    localparam int unsigned N  = XLEN / CHUNK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(CHUNK + 1);

    localparam logic [2:0] F3_CNTB = 3'b000;
    localparam logic [2:0] F3_CLZ  = 3'b001;
    localparam logic [2:0] F3_CTZ  = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                state_q, state_d;
    logic [XLEN-1:0]       op_q;
    logic                  cnt_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [KW-1:0]         k_q;
    logic [XLEN-1:0]       acc_q, acc_d;
    logic                  found_q, found_d;
    logic [XLEN-1:0]       result_data_q;
    logic [ID_WIDTH-1:0]   result_id_q;

    logic                  hs_accept;
    logic                  last_chunk;
    logic [XLEN-1:0]       rs1_rev;
    logic [CHUNK-1:0]      chunk;
    logic [CW-1:0]         chunk_pop;
    logic [CW-1:0]         chunk_lz;
    logic                  lz_seen;

    assign issue_accept_o = (opcode_i == OPCODE) &&
                            (funct3_i == F3_CNTB || funct3_i == F3_CLZ || funct3_i == F3_CTZ);
    assign hs_accept      = issue_valid_i && issue_ready_o && issue_accept_o;
    assign last_chunk     = (k_q == KW'(N - 1));
    assign result_data_o  = result_data_q;
    assign result_id_o    = result_id_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hs_accept) state_d = BUSY;
            BUSY: begin
                if (kill_i)          state_d = IDLE;
                else if (last_chunk) state_d = DONE;
            end
            DONE: if (kill_i || result_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue_ready_o  = (state_q == IDLE);
        result_valid_o = (state_q == DONE);
        busy_o         = (state_q != IDLE);
    end

    // CTZ reuses the CLZ datapath on the bit-reversed operand.
    always_comb begin
        rs1_rev = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            rs1_rev[i] = rs1_i[XLEN-1-i];
        end
    end

    // CNTB walks chunks from the LSB end, CLZ/CTZ from the MSB end.
    assign chunk = cnt_q ? op_q[CHUNK-1:0] : op_q[XLEN-1 -: CHUNK];

    always_comb begin
        chunk_pop = '0;
        chunk_lz  = '0;
        lz_seen   = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            chunk_pop = chunk_pop + CW'(chunk[i]);
            if (!lz_seen && !chunk[i]) begin
                chunk_lz = chunk_lz + CW'(1);
            end
            lz_seen = lz_seen | chunk[i];
        end
    end

    always_comb begin
        acc_d   = acc_q;
        found_d = found_q;
        if (cnt_q) begin
            acc_d = acc_q + XLEN'(chunk_pop);
        end else if (!found_q) begin
            acc_d   = acc_q + XLEN'(chunk_lz);
            found_d = |chunk;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q          <= '0;
            cnt_q         <= 1'b0;
            id_q          <= '0;
            k_q           <= '0;
            acc_q         <= '0;
            found_q       <= 1'b0;
            result_data_q <= '0;
            result_id_q   <= '0;
        end else if (hs_accept) begin
            op_q    <= (funct3_i == F3_CTZ) ? rs1_rev : rs1_i;
            cnt_q   <= (funct3_i == F3_CNTB);
            id_q    <= issue_id_i;
            k_q     <= '0;
            acc_q   <= '0;
            found_q <= 1'b0;
        end else if (state_q == BUSY && !kill_i) begin
            k_q     <= k_q + KW'(1);
            op_q    <= cnt_q ? (op_q >> CHUNK) : (op_q << CHUNK);
            acc_q   <= acc_d;
            found_q <= found_d;
            if (last_chunk) begin
                result_data_q <= acc_d;
                result_id_q   <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_custom_cnt_unit.sv
// Directed bench for custom_cnt_unit (XLEN=32, CHUNK=8): counts, latency, reject, backpressure, kill, reset.
module tb_custom_cnt_unit;

    localparam logic [6:0] OPC = 7'b0001011;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic        issue_accept_o;
    logic [3:0]  issue_id_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic        kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic        busy_o;

    int n_total = 0;
    int n_pass  = 0;

    custom_cnt_unit dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_accept_o (issue_accept_o),
        .issue_id_i     (issue_id_i),
        .opcode_i       (opcode_i),
        .funct3_i       (funct3_i),
        .rs1_i          (rs1_i),
        .kill_i         (kill_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_id_o    (result_id_o),
        .result_data_o  (result_data_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Leaves time 2 units after a rising edge: registered outputs settled, inputs safe to drive.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Issue in cycle 0, expect result_valid in cycle 5, take it, check return to IDLE.
    task automatic do_op(input string tag, input logic [3:0] id, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] exp_data);
        int n;
        issue_valid_i = 1'b1;
        issue_id_i    = id;
        opcode_i      = OPC;
        funct3_i      = f3;
        rs1_i         = rs1;
        #1;
        chk({tag, "_accept"}, issue_accept_o, 1'b1);
        tick();
        issue_valid_i = 1'b0;
        rs1_i         = '0;
        n = 1;
        while (!result_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_data"}, result_data_o, exp_data);
        chk({tag, "_id"}, result_id_o, id);
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        #1;
        chk({tag, "_idle"}, {result_valid_o, busy_o, issue_ready_o}, 3'b001);
    endtask

    initial begin
        rst_ni         = 1'b0;
        issue_valid_i  = 1'b0;
        issue_id_i     = '0;
        opcode_i       = '0;
        funct3_i       = '0;
        rs1_i          = '0;
        kill_i         = 1'b0;
        result_ready_i = 1'b0;
        #12;
        chk("rst_valid", result_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_data", result_data_o, 32'd0);
        chk("rst_id", result_id_o, 4'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("rst_ready", issue_ready_o, 1'b1);

        // CNTB with cycle-by-cycle busy/valid trace
        issue_valid_i = 1'b1;
        issue_id_i    = 4'd3;
        opcode_i      = OPC;
        funct3_i      = 3'b000;
        rs1_i         = 32'hF0F0000F;
        #1;
        chk("cntb_accept", issue_accept_o, 1'b1);
        chk("cntb_ready0", issue_ready_o, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            issue_valid_i = 1'b0;
            chk($sformatf("cntb_busy_c%0d", c), busy_o, 1'b1);
            chk($sformatf("cntb_valid_c%0d", c), result_valid_o, (c == 5));
            chk($sformatf("cntb_ready_c%0d", c), issue_ready_o, 1'b0);
        end
        chk("cntb_data", result_data_o, 32'd12);
        chk("cntb_id", result_id_o, 4'd3);
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        chk("cntb_idle", {result_valid_o, busy_o, issue_ready_o}, 3'b001);

        do_op("clz_1", 4'd1, 3'b001, 32'h00010000, 32'd15);
        do_op("ctz_1", 4'd2, 3'b010, 32'h00010000, 32'd16);
        do_op("clz_0", 4'd4, 3'b001, 32'h00000000, 32'd32);
        do_op("ctz_msb", 4'd5, 3'b010, 32'h80000000, 32'd31);
        do_op("ctz_0", 4'd6, 3'b010, 32'h00000000, 32'd32);
        do_op("clz_ones", 4'd7, 3'b001, 32'hFFFFFFFF, 32'd0);
        do_op("cntb_0", 4'd8, 3'b000, 32'h00000000, 32'd0);

        // Unsupported funct3, then foreign opcode
        issue_valid_i = 1'b1;
        issue_id_i    = 4'd9;
        opcode_i      = OPC;
        funct3_i      = 3'b111;
        rs1_i         = 32'h1234;
        #1;
        chk("rej_f3_accept", issue_accept_o, 1'b0);
        chk("rej_f3_ready", issue_ready_o, 1'b1);
        tick();
        opcode_i = 7'h33;
        funct3_i = 3'b000;
        #1;
        chk("rej_f3_busy", busy_o, 1'b0);
        chk("rej_opc_accept", issue_accept_o, 1'b0);
        tick();
        issue_valid_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("rej_quiet_c%0d", c), {result_valid_o, busy_o}, 2'b00);
            tick();
        end

        // Backpressure: result held across 3 DONE cycles with ready low
        issue_valid_i = 1'b1;
        issue_id_i    = 4'd10;
        opcode_i      = OPC;
        funct3_i      = 3'b000;
        rs1_i         = 32'hFFFFFFFF;
        tick();
        issue_valid_i = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_valid_%0d", c), result_valid_o, 1'b1);
            chk($sformatf("bp_data_%0d", c), result_data_o, 32'd32);
            chk($sformatf("bp_id_%0d", c), result_id_o, 4'd10);
            chk($sformatf("bp_ready_%0d", c), issue_ready_o, 1'b0);
            if (c < 2) tick();
        end
        // Result handshake cycle: a new offer must not be taken
        result_ready_i = 1'b1;
        issue_valid_i  = 1'b1;
        issue_id_i     = 4'd11;
        #1;
        chk("bp_nooverlap_ready", issue_ready_o, 1'b0);
        tick();
        result_ready_i = 1'b0;
        issue_valid_i  = 1'b0;
        chk("bp_idle", {result_valid_o, busy_o, issue_ready_o}, 3'b001);

        // Kill in second BUSY cycle
        issue_valid_i = 1'b1;
        issue_id_i    = 4'd12;
        funct3_i      = 3'b001;
        rs1_i         = 32'h00F00000;
        tick();
        issue_valid_i = 1'b0;
        tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kill_ready", issue_ready_o, 1'b1);
        chk("kill_busy", busy_o, 1'b0);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("kill_novalid_%0d", c), result_valid_o, 1'b0);
            tick();
        end
        do_op("kill_next", 4'd13, 3'b001, 32'h00000001, 32'd31);

        // Asynchronous reset in the middle of BUSY
        issue_valid_i = 1'b1;
        issue_id_i    = 4'd14;
        funct3_i      = 3'b000;
        rs1_i         = 32'h0000FFFF;
        tick();
        issue_valid_i = 1'b0;
        tick();
        chk("arst_pre_busy", busy_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_ready", issue_ready_o, 1'b1);
        chk("arst_valid", result_valid_o, 1'b0);
        chk("arst_data", result_data_o, 32'd0);
        chk("arst_id", result_id_o, 4'd0);
        #2;
        rst_ni = 1'b1;
        tick();
        chk("arst_quiet", {result_valid_o, busy_o}, 2'b00);
        do_op("arst_next", 4'd2, 3'b000, 32'h00000003, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
